// File: rtl/simple_counter_mod.sv
// Parametrised modulo up/down counter with prescaled clock-enable, synchronous
// clear/load, a one-cycle terminal-count pulse and a sticky overflow flag.
module simple_counter_mod #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MODULUS  = 2 ** WIDTH,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] CMAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);
  localparam logic [PW-1:0]    PMAX  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    P_ONE = PW'(1);

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_STEP
  } op_e;

  op_e              op;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;
  logic             at_bound;
  logic             boundary;

  // Per-edge operation, in priority order; reset is handled in the register.
  always_comb begin
    op = OP_HOLD;
    if (clr) begin
      op = OP_CLR;
    end else if (load) begin
      op = OP_LOAD;
    end else if (en && (presc == PMAX)) begin
      op = OP_STEP;
    end
  end

  always_comb begin
    count_nxt = count;
    presc_nxt = presc;
    boundary  = 1'b0;
    at_bound  = up ? (count == CMAX) : (count == '0);

    unique case (op)
      OP_CLR: begin
        count_nxt = '0;
        presc_nxt = '0;
      end
      OP_LOAD: begin
        count_nxt = (load_val > CMAX) ? CMAX : load_val;
        presc_nxt = '0;
      end
      OP_STEP: begin
        presc_nxt = '0;
        boundary  = at_bound;
        if (at_bound) begin
          // Boundary step: hold in saturate mode, otherwise wrap to the far end.
          if (!sat) begin
            count_nxt = up ? '0 : CMAX;
          end
        end else begin
          count_nxt = up ? (count + C_ONE) : (count - C_ONE);
        end
      end
      OP_HOLD: begin
        if (en) begin
          presc_nxt = presc + P_ONE;
        end
      end
      default: begin
        count_nxt = count;
      end
    endcase

    tc_nxt  = boundary;
    ovf_nxt = boundary | (ovf & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      presc <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      presc <= presc_nxt;
      tc    <= tc_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_simple_counter_mod.sv
// Bench for simple_counter_mod: three configurations share one stimulus stream,
// each checked every edge against an arithmetic reference model plus fixed vectors.
module tb_simple_counter_mod;

  logic       clk = 1'b0;
  logic       rst_n, en, up, sat, clr, load, ovf_clr;
  logic [7:0] load_val;

  logic [7:0] cnt_a, cnt_b;
  logic [3:0] cnt_c;
  logic       tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state per instance: a=(8,10,1) b=(8,10,3) c=(4,16,1)
  int mod_m[3]  = '{10, 10, 16};
  int pre_m[3]  = '{1, 3, 1};
  int lvmax[3]  = '{255, 255, 15};
  int mc[3]     = '{0, 0, 0};
  int mp[3]     = '{0, 0, 0};
  int mt[3]     = '{0, 0, 0};
  int mo[3]     = '{0, 0, 0};

  always #5 clk = ~clk;

  simple_counter_mod #(.WIDTH(8), .MODULUS(10), .PRESCALE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat(sat), .clr(clr), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr), .count(cnt_a), .tc(tc_a), .ovf(ovf_a)
  );

  simple_counter_mod #(.WIDTH(8), .MODULUS(10), .PRESCALE(3)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat(sat), .clr(clr), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr), .count(cnt_b), .tc(tc_b), .ovf(ovf_b)
  );

  simple_counter_mod #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat(sat), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .ovf_clr(ovf_clr), .count(cnt_c), .tc(tc_c), .ovf(ovf_c)
  );

  typedef struct {
    logic       rst_n, en, up, sat, clr, load;
    logic [7:0] lv;
    logic       oc;
    int         ec, et, eo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input logic r, input logic e, input logic u, input logic s,
                               input logic c, input logic l, input int lv, input logic oc,
                               input int ec, input int et, input int eo);
    vec_t v;
    v.rst_n = r; v.en = e; v.up = u; v.sat = s; v.clr = c; v.load = l;
    v.lv = 8'(lv); v.oc = oc; v.ec = ec; v.et = et; v.eo = eo;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic s,
                       input logic c, input logic l, input int lv, input logic oc);
    rst_n = r; en = e; up = u; sat = s; clr = c; load = l; load_val = 8'(lv); ovf_clr = oc;
  endtask

  // Behavioural rule set: priority rst_n > clr > load > prescaled step.
  task automatic model_step(input int i);
    int m, lv, bnd;
    m   = mod_m[i];
    bnd = 0;
    if (!rst_n) begin
      mc[i] = 0; mp[i] = 0; mt[i] = 0; mo[i] = 0;
      return;
    end
    if (clr) begin
      mc[i] = 0; mp[i] = 0;
    end else if (load) begin
      lv    = int'(load_val) & lvmax[i];
      mc[i] = (lv > m - 1) ? m - 1 : lv;
      mp[i] = 0;
    end else if (en) begin
      if (mp[i] == pre_m[i] - 1) begin
        mp[i] = 0;
        bnd   = up ? (mc[i] == m - 1) : (mc[i] == 0);
        if (!(bnd && sat))
          mc[i] = up ? (mc[i] + 1) % m : (mc[i] + m - 1) % m;
      end else begin
        mp[i] = mp[i] + 1;
      end
    end
    mt[i] = bnd;
    mo[i] = bnd ? 1 : (ovf_clr ? 0 : mo[i]);
  endtask

  task automatic tick();
    int ac[3], at[3], ao[3];
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    ac[0] = int'(cnt_a); at[0] = int'(tc_a); ao[0] = int'(ovf_a);
    ac[1] = int'(cnt_b); at[1] = int'(tc_b); ao[1] = int'(ovf_b);
    ac[2] = int'(cnt_c); at[2] = int'(tc_c); ao[2] = int'(ovf_c);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model[%0d].count", i), ac[i], mc[i]);
      check($sformatf("model[%0d].tc", i), at[i], mt[i]);
      check($sformatf("model[%0d].ovf", i), ao[i], mo[i]);
    end
  endtask

  initial begin
    int tcs;
    drive(0, 0, 1, 0, 0, 0, 0, 0);

    // Fixed vectors for instance a (MODULUS=10, PRESCALE=1)
    tbl.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 9; k++) tbl.push_back(mkv(1, 1, 1, 0, 0, 0, 0, 0, k, 0, 0));
    tbl.push_back(mkv(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mkv(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mkv(1, 1, 1, 0, 0, 1, 3, 0, 3, 0, 1));
    tbl.push_back(mkv(1, 1, 0, 1, 0, 0, 0, 0, 2, 0, 1));
    tbl.push_back(mkv(1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mkv(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkv(1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mkv(1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 0, 9, 1, 1));
    tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0, 1, 200, 0, 9, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 1, 9, 1, 1));
    tbl.push_back(mkv(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1));
    for (int k = 1; k <= 7; k++) tbl.push_back(mkv(1, 1, 1, 0, 0, 0, 0, 0, k, 0, 1));
    tbl.push_back(mkv(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mkv(1, 1, 1, 0, 0, 0, 0, 0, 2, 0, 0));

    foreach (tbl[j]) begin
      drive(tbl[j].rst_n, tbl[j].en, tbl[j].up, tbl[j].sat, tbl[j].clr, tbl[j].load,
            int'(tbl[j].lv), tbl[j].oc);
      tick();
      check($sformatf("tbl[%0d].count", j), int'(cnt_a), tbl[j].ec);
      check($sformatf("tbl[%0d].tc", j), int'(tc_a), tbl[j].et);
      check($sformatf("tbl[%0d].ovf", j), int'(ovf_a), tbl[j].eo);
    end

    // Prescaler phase on instance b (PRESCALE=3)
    drive(1, 0, 1, 0, 1, 0, 0, 1);
    tick();
    for (int k = 1; k <= 9; k++) begin
      drive(1, 1, 1, 0, 0, 0, 0, 0);
      tick();
      check($sformatf("presc.run%0d", k), int'(cnt_b), k / 3);
    end
    tick();
    check("presc.cycle10", int'(cnt_b), 3);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      tick();
      check($sformatf("presc.hold%0d", k), int'(cnt_b), 3);
    end
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    tick();
    check("presc.resume1", int'(cnt_b), 3);
    tick();
    check("presc.resume2", int'(cnt_b), 4);

    // Full-range wrap on instance c (WIDTH=4, MODULUS=16)
    drive(1, 0, 1, 0, 1, 0, 0, 1);
    tick();
    tcs = 0;
    for (int k = 0; k < 16; k++) begin
      drive(1, 1, 1, 0, 0, 0, 0, 0);
      tick();
      tcs += int'(tc_c);
    end
    check("wrap16.count", int'(cnt_c), 0);
    check("wrap16.tc_pulses", tcs, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    check("wrap16.down_count", int'(cnt_c), 15);
    check("wrap16.down_tc", int'(tc_c), 1);

    // Randomised traffic, every edge checked against the models
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 14) == 0, int'($urandom_range(0, 255)),
            $urandom_range(0, 7) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
